// File: rtl/posit32_decode_pipe.sv
// Pipelined posit32 (es=2) field decoder: sign, scale = 4k+e, 28-bit mantissa, zero/NaR flags.
// Define POSIT32_DECODE_MID_REG_EN to add a register between regime count and extract (latency 3 vs 2).

module posit32_count_regime (
    input  logic [30:0] body,
    output logic [4:0]  run_len,
    output logic        regime_bit
);
    logic [30:0] flip;

    // Run length of the leading bit equals the leading-zero count after inverting a run of ones.
    always_comb begin
        regime_bit = body[30];
        flip       = body[30] ? ~body : body;
        run_len    = 5'd31;
        for (int i = 0; i <= 30; i++) begin
            if (flip[i]) run_len = 5'(30 - i);
        end
    end
endmodule

module posit32_decode_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_posit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [8:0]  out_scale,
    output logic [27:0] out_mant,
    output logic        out_zero,
    output logic        out_nar
);
    // Handshake: a stage transfers on a rising edge when valid && ready; a stage
    // loads when empty or when its current content leaves in the same cycle.
    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [31:0] s1_abs_q, s1_abs_d;
    logic        s1_zero_q, s1_zero_d;
    logic        s1_nar_q, s1_nar_d;

    logic        out_valid_q, out_valid_d;
    logic        out_sign_q, out_sign_d;
    logic [8:0]  out_scale_q, out_scale_d;
    logic [27:0] out_mant_q, out_mant_d;
    logic        out_zero_q, out_zero_d;
    logic        out_nar_q, out_nar_d;

    logic        out_take, s1_take;
    logic [4:0]  cnt_m;
    logic        cnt_r;
    logic [8:0]  cnt_k;

    logic        x_valid, x_sign, x_zero, x_nar;
    logic [31:0] x_abs;
    logic [4:0]  x_m;
    logic [8:0]  x_k;

    logic [5:0]  shamt;
    logic [31:0] shifted;
    logic [28:0] field;
    logic        ext_sign;
    logic [8:0]  ext_scale;
    logic [27:0] ext_mant;

    posit32_count_regime u_count (
        .body       (s1_abs_q[30:0]),
        .run_len    (cnt_m),
        .regime_bit (cnt_r)
    );

    assign cnt_k = cnt_r ? ({4'd0, cnt_m} - 9'd1) : (9'd0 - {4'd0, cnt_m});

`ifdef POSIT32_DECODE_MID_REG_EN
    logic        mid_take;
    logic        mid_valid_q, mid_valid_d;
    logic        mid_sign_q, mid_sign_d;
    logic [31:0] mid_abs_q, mid_abs_d;
    logic [4:0]  mid_m_q, mid_m_d;
    logic [8:0]  mid_k_q, mid_k_d;
    logic        mid_zero_q, mid_zero_d;
    logic        mid_nar_q, mid_nar_d;

    always_comb begin
        mid_valid_d = mid_valid_q;
        mid_sign_d  = mid_sign_q;
        mid_abs_d   = mid_abs_q;
        mid_m_d     = mid_m_q;
        mid_k_d     = mid_k_q;
        mid_zero_d  = mid_zero_q;
        mid_nar_d   = mid_nar_q;
        if (mid_take) mid_valid_d = s1_valid_q;
        if (mid_take && s1_valid_q) begin
            mid_sign_d = s1_sign_q;
            mid_abs_d  = s1_abs_q;
            mid_m_d    = cnt_m;
            mid_k_d    = cnt_k;
            mid_zero_d = s1_zero_q;
            mid_nar_d  = s1_nar_q;
        end
    end

    assign x_valid = mid_valid_q;
    assign x_sign  = mid_sign_q;
    assign x_abs   = mid_abs_q;
    assign x_m     = mid_m_q;
    assign x_k     = mid_k_q;
    assign x_zero  = mid_zero_q;
    assign x_nar   = mid_nar_q;
`else
    assign x_valid = s1_valid_q;
    assign x_sign  = s1_sign_q;
    assign x_abs   = s1_abs_q;
    assign x_m     = cnt_m;
    assign x_k     = cnt_k;
    assign x_zero  = s1_zero_q;
    assign x_nar   = s1_nar_q;
`endif

    // Ready chain runs combinationally from out_ready back to in_ready.
    always_comb begin
        out_take = !out_valid_q || out_ready;
`ifdef POSIT32_DECODE_MID_REG_EN
        mid_take = !mid_valid_q || out_take;
        s1_take  = !s1_valid_q || mid_take;
`else
        s1_take  = !s1_valid_q || out_take;
`endif
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_abs_d   = s1_abs_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        if (s1_take) s1_valid_d = in_valid;
        if (s1_take && in_valid) begin
            s1_sign_d = in_posit[31];
            s1_abs_d  = in_posit[31] ? (~in_posit + 32'd1) : in_posit;
            s1_zero_d = (in_posit == 32'h0000_0000);
            s1_nar_d  = (in_posit == 32'h8000_0000);
        end
    end

    assign in_ready = s1_take;

    // Drop sign, run and terminator; a full-length run leaves nothing behind.
    always_comb begin
        shamt     = {1'b0, x_m} + 6'd2;
        shifted   = shamt[5] ? 32'd0 : (x_abs << shamt[4:0]);
        field     = 29'(shifted >> 3);
        ext_sign  = x_sign;
        ext_scale = (x_k << 2) + {7'd0, field[28:27]};
        ext_mant  = {1'b1, field[26:0]};
        if (x_zero || x_nar) begin
            ext_sign  = 1'b0;
            ext_scale = 9'd0;
            ext_mant  = 28'd0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_scale_d = out_scale_q;
        out_mant_d  = out_mant_q;
        out_zero_d  = out_zero_q;
        out_nar_d   = out_nar_q;
        if (out_take) out_valid_d = x_valid;
        if (out_take && x_valid) begin
            out_sign_d  = ext_sign;
            out_scale_d = ext_scale;
            out_mant_d  = ext_mant;
            out_zero_d  = x_zero;
            out_nar_d   = x_nar;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_abs_q    <= 32'd0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
`ifdef POSIT32_DECODE_MID_REG_EN
            mid_valid_q <= 1'b0;
            mid_sign_q  <= 1'b0;
            mid_abs_q   <= 32'd0;
            mid_m_q     <= 5'd0;
            mid_k_q     <= 9'd0;
            mid_zero_q  <= 1'b0;
            mid_nar_q   <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_scale_q <= 9'd0;
            out_mant_q  <= 28'd0;
            out_zero_q  <= 1'b0;
            out_nar_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_abs_q    <= s1_abs_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
`ifdef POSIT32_DECODE_MID_REG_EN
            mid_valid_q <= mid_valid_d;
            mid_sign_q  <= mid_sign_d;
            mid_abs_q   <= mid_abs_d;
            mid_m_q     <= mid_m_d;
            mid_k_q     <= mid_k_d;
            mid_zero_q  <= mid_zero_d;
            mid_nar_q   <= mid_nar_d;
`endif
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_scale_q <= out_scale_d;
            out_mant_q  <= out_mant_d;
            out_zero_q  <= out_zero_d;
            out_nar_q   <= out_nar_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_scale = out_scale_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;
    assign out_nar   = out_nar_q;
endmodule

// File: tb/tb_posit32_decode_pipe.sv
// Directed and randomised-backpressure bench for posit32_decode_pipe (either depth setting).
module tb_posit32_decode_pipe;
`ifdef POSIT32_DECODE_MID_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_posit;
    logic        out_valid, out_ready;
    logic        out_sign, out_zero, out_nar;
    logic [8:0]  out_scale;
    logic [27:0] out_mant;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int popped = 0;
    logic mon_en = 1'b0;
    logic rand_en = 1'b0;
    logic [39:0] exp_q[$];
    int xfer_log[$];
    int pop_log[$];
    logic [39:0] obs_vec;
    logic [39:0] stall_vec = '0;
    logic stall_prev = 1'b0;

    posit32_decode_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_scale (out_scale),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_nar   (out_nar)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs_vec = {out_sign, out_scale, out_mant, out_zero, out_nar};

    function automatic logic [39:0] pk(input logic s, input int sc, input logic [27:0] m,
                                       input logic z, input logic n);
        return {s, 9'(sc), m, z, n};
    endfunction

    // Reference decode: walk the bits one at a time.
    function automatic logic [39:0] ref_decode(input logic [31:0] p);
        logic [31:0] a;
        logic        r;
        logic [26:0] f;
        int i, m, e, k;
        if (p == 32'h0000_0000) return pk(1'b0, 0, 28'd0, 1'b1, 1'b0);
        if (p == 32'h8000_0000) return pk(1'b0, 0, 28'd0, 1'b0, 1'b1);
        a = p[31] ? (~p + 32'd1) : p;
        r = a[30];
        m = 0;
        i = 30;
        while (i >= 0 && a[i] == r) begin
            m++;
            i--;
        end
        i--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        f = '0;
        for (int j = 26; j >= 0; j--) begin
            f[j] = (i >= 0) ? a[i] : 1'b0;
            i--;
        end
        k = r ? (m - 1) : -m;
        return pk(p[31], 4 * k + e, {1'b1, f}, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else if (mon_en) begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_fields", 64'(obs_vec), 64'(stall_vec));
            end
            if (out_valid && out_ready) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL out_unexpected: observed %h expected no result", obs_vec);
                end
                if (exp_q.size() > 0) begin
                    check("out_data", 64'(obs_vec), 64'(exp_q.pop_front()));
                    pop_log.push_back(cyc);
                    popped++;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_vec  = obs_vec;
        end
    end

    // Driver: present one posit and hold it until accepted.
    task automatic send(input logic [31:0] p, input logic [39:0] e);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_posit = p;
        for (int n = 0; n < 500 && !ok; n++) begin
            if (rand_en) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL send_timeout: in_ready observed 0 expected 1 for %h", p);
        end
        if (ok) begin
            exp_q.push_back(e);
            xfer_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        in_valid = 1'b0;
        in_posit = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fields", 64'(obs_vec), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;
        out_ready = 1'b1;

        // Back-to-back burst: latency and one result per cycle.
        xfer_log.delete();
        pop_log.delete();
        send(32'h4000_0000, pk(1'b0, 0, 28'h800_0000, 1'b0, 1'b0));
        send(32'hC000_0000, pk(1'b1, 0, 28'h800_0000, 1'b0, 1'b0));
        send(32'h4800_0000, pk(1'b0, 1, 28'h800_0000, 1'b0, 1'b0));
        send(32'h4400_0000, pk(1'b0, 0, 28'hC00_0000, 1'b0, 1'b0));
        drain();
        check("burst_count", 64'(pop_log.size()), 64'd4);
        if (pop_log.size() == 4 && xfer_log.size() == 4) begin
            check("burst_latency", 64'(pop_log[0] - xfer_log[0]), 64'(LAT));
            check("burst_spacing", 64'(pop_log[3] - pop_log[0]), 64'd3);
        end

        // Extremes and specials.
        send(32'h7FFF_FFFF, pk(1'b0, 120, 28'h800_0000, 1'b0, 1'b0));
        send(32'h0000_0001, pk(1'b0, -120, 28'h800_0000, 1'b0, 1'b0));
        send(32'h7FFF_FFFE, pk(1'b0, 116, 28'h800_0000, 1'b0, 1'b0));
        send(32'h5000_0000, pk(1'b0, 2, 28'h800_0000, 1'b0, 1'b0));
        send(32'h8000_0001, pk(1'b1, 120, 28'h800_0000, 1'b0, 1'b0));
        send(32'h0000_0000, pk(1'b0, 0, 28'd0, 1'b1, 1'b0));
        send(32'h8000_0000, pk(1'b0, 0, 28'd0, 1'b0, 1'b1));
        drain();

        // Fill the pipe against a stalled output, then hold in_valid.
        out_ready = 1'b0;
        send(32'h4800_0000, pk(1'b0, 1, 28'h800_0000, 1'b0, 1'b0));
        send(32'h5000_0000, pk(1'b0, 2, 28'h800_0000, 1'b0, 1'b0));
        if (LAT == 3) send(32'h4400_0000, pk(1'b0, 0, 28'hC00_0000, 1'b0, 1'b0));
        in_valid = 1'b1;
        in_posit = 32'h7FFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check("in_ready_full", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("in_ready_release", 64'(in_ready), 64'd1);
        exp_q.push_back(pk(1'b0, 120, 28'h800_0000, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with transfers in flight.
        send(32'h4800_0000, pk(1'b0, 1, 28'h800_0000, 1'b0, 1'b0));
        send(32'h5000_0000, pk(1'b0, 2, 28'h800_0000, 1'b0, 1'b0));
        send(32'h4400_0000, pk(1'b0, 0, 28'hC00_0000, 1'b0, 1'b0));
        #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("reset_drop_valid", 64'(out_valid), 64'd0);
        check("reset_drop_fields", 64'(obs_vec), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h4000_0000, pk(1'b0, 0, 28'h800_0000, 1'b0, 1'b0));
        drain();

        // Random posits under random backpressure.
        base = popped;
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] p;
            p = $urandom();
            send(p, ref_decode(p));
        end
        rand_en = 1'b0;
        drain();
        check("random_count", 64'(popped - base), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/posit32_decode_pipe.md
# posit32_decode_pipe

Pipelined posit32 (es = 2) field decoder with valid/ready handshakes on both sides. Takes raw 32-bit posits and produces sign, a combined scale (4·k + e), and a normalised 28-bit mantissa with the hidden bit set, plus zero/NaR flags. It sits between the operand registers and the arithmetic units. It instantiates `posit32_count_regime` for regime run-length detection and adds the absolute-value, extraction, shift and flow-control logic around it.

## Interface
- No parameters. Depth is selected by the macro in Configuration.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an input posit is presented.
- `in_ready` output 1: block accepts the input this cycle.
- `in_posit` input 32: raw posit32 bit pattern.
- `out_valid` output 1: a decoded result is presented.
- `out_ready` input 1: downstream accepts the result this cycle.
- `out_sign` output 1: sign bit of the input.
- `out_scale` output 9: signed, 4·k + e, range [-120, 120].
- `out_mant` output 28: bit 27 is the hidden 1, bits 26:0 are the fraction, left-aligned and zero-padded.
- `out_zero` output 1: the input was 0x00000000.
- `out_nar` output 1: the input was 0x80000000.

## Operation
- Transfer occurs on a rising edge when valid && ready, on either port.
- S1 (accept):
  - Registers the sign.
  - Registers the absolute value: two's complement of `in_posit` if the sign is set, else `in_posit`.
  - Registers the zero and NaR flags, detected on the raw input.
- S2 (count): feeds the absolute value to `posit32_count_regime` to obtain the regime run length m (1..31) of bits 30:0 and the leading regime bit r.
  - k = m − 1 if r = 1, else k = −m.
- S3 (extract):
  - Shift the absolute value left by m + 2 (run plus sign plus terminator), clamped to zero-fill.
  - e = top 2 bits after the shift. Exponent bits lost off the end read as 0.
  - Fraction = the next 27 bits, zero-filled.
  - `out_scale` = 4·k + e.
  - `out_mant` = {1'b1, fraction}.
- Zero or NaR: `out_sign`, `out_scale` and `out_mant` are forced to 0 and the matching flag is set.
  - The regime result is ignored for these inputs.
  - `out_zero` and `out_nar` are never set together.
- Flow control uses a per-stage valid bit.
  - A stage loads when it is empty, or when its content moves forward this cycle.
  - `in_ready` = !s1_valid || s1 advancing. This is a combinational chain back from `out_ready`.
  - Full throughput: one posit per cycle while `out_ready` = 1.
- While `out_valid` = 1 and `out_ready` = 0, all output fields hold stable and upstream stages stall without loss or duplication.
- Results leave in input order. No reordering or drop.

## Timing
- Latency from input transfer to `out_valid` is 3 cycles with the mid register (S2/S3 split), or 2 cycles without it.
- Throughput is 1 result per cycle. A bubble occurs only when `in_valid` = 0.
- Reset values: `out_valid` = 0, all output fields 0, all internal stage valids 0.
  - `in_ready` = 1 combinationally after reset deassertion.
- Reset asserted mid-operation: all in-flight data is discarded immediately and asynchronously. Nothing emerges after release.
- `out_ready` may toggle every cycle. `in_valid` may be held across stalls, and the data must not be double-captured.

## Configuration
- `POSIT32_DECODE_MID_REG_EN` defined:
  - A pipeline register sits between the regime count (S2) and the extract/shift (S3).
  - Latency is 3.
  - Intended for the 32-bit critical path at target frequency.
- Not defined:
  - S2 and S3 are one combinational stage.
  - Latency is 2.
  - Handshake behaviour and results are otherwise identical.

## Test plan
- Stream 0x40000000, 0xC0000000, 0x48000000, 0x44000000 with `out_ready` = 1 → four consecutive results:
  - (0, 0, 0x8000000)
  - (1, 0, 0x8000000)
  - (0, 1, 0x8000000)
  - (0, 0, 0xC000000)
  - Each arrives after the configured latency, one per cycle.
- Extremes:
  - 0x7FFFFFFF → scale 120, mant 0x8000000.
  - 0x00000001 → scale −120, mant 0x8000000.
  - 0x7FFFFFFE → scale 116, mant 0x8000000.
  - 0x50000000 → scale 2.
- Specials:
  - 0x00000000 → `out_zero` = 1, `out_nar` = 0, other fields 0.
  - 0x80000000 → `out_nar` = 1, `out_zero` = 0, other fields 0.
- Backpressure: random `out_ready` at 50% with continuous `in_valid`, 1000 random posits → output sequence equals reference-model decode in order, no loss or duplication, and fields stay stable whenever `out_valid` && !`out_ready`.
- Reset pulse while 3 transfers are in flight → `out_valid` drops immediately, no stale result after release, and the next input 0x40000000 decodes to scale 0.
- Run both macro settings and check latency (2 vs 3) and `in_ready` deasserting only when the pipe is full and `out_ready` = 0.
